sobel_frame_collector: RTL and testbench
========================================

SOBEL_FRAME_COLLECTOR -- requirements
Module: sobel_frame_collector

Interface
REQ-001 Parameter res_x, default 30, full frame width in pixels; SHALL be at least 3.
REQ-002 Parameter res_y, default 30, full frame height in pixels; SHALL be at least 3.
REQ-003 Parameter THRESH, default 8'd128, binarization threshold; used only when SOBEL_BIN_EN is defined.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  high when in_pix holds a valid interior gradient pixel.
REQ-007 in_pix  input  8  gradient magnitude, raster order, (res_x-2)x(res_y-2) pixels per frame.
REQ-008 in_ready  output  1  high when the block accepts in_pix.
REQ-009 out_valid  output  1  high when out_pix holds a valid full-frame pixel.
REQ-010 out_pix  output  8  full-frame pixel, raster order, res_x x res_y pixels.
REQ-011 out_ready  input  1  downstream accepts out_pix.
REQ-012 frame_done  output  1  one-cycle pulse after the last output pixel transfers.
REQ-013 busy  output  1  high in DRAIN and DONE.

Function
REQ-014 The FSM SHALL have exactly three states: COLLECT, DRAIN and DONE.
REQ-015 In COLLECT, in_ready SHALL be 1; in DRAIN and DONE, in_ready SHALL be 0.
REQ-016 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-017 Each transfer SHALL store in_pix at interior position (w_row, w_col) of a (res_y-2)x(res_x-2) buffer.
REQ-018 w_col SHALL wrap to 0 at res_x-3, and w_row SHALL increment on that wrap.
REQ-019 The transfer at (res_y-3, res_x-3) SHALL move the FSM to DRAIN on the next cycle and SHALL clear w_row and w_col.
REQ-020 In DRAIN, out_valid SHALL be 1, and out_pix SHALL be the pixel at read position (r_row, r_col) of the full frame.
REQ-021 Border positions (r_row = 0 or res_y-1, or r_col = 0 or res_x-1) SHALL output 8'd0.
REQ-022 Interior positions SHALL output buffer[r_row-1][r_col-1].
REQ-023 An output transfer SHALL occur when out_valid=1 and out_ready=1; the read position SHALL advance in raster order only on a transfer.
REQ-024 While out_valid=1 and out_ready=0, out_pix SHALL hold stable.
REQ-025 The transfer at (res_y-1, res_x-1) SHALL move the FSM to DONE and SHALL clear r_row and r_col.
REQ-026 DONE SHALL last exactly one cycle, with frame_done=1 and out_valid=0, and SHALL then return to COLLECT.
REQ-027 Output latency: the first out_valid=1 SHALL occur exactly 1 cycle after the last input transfer.
REQ-028 The first output transfer SHALL be possible on that same cycle.
REQ-029 Counters SHALL be wide enough for res_x and res_y, and address arithmetic SHALL not truncate.
REQ-030 Frames SHALL be processed back-to-back with no cap on frame count.

Reset
REQ-031 reset=0 SHALL immediately force state COLLECT, clear all counters, and set in_ready=1, out_valid=0, out_pix=0, frame_done=0, busy=0.
REQ-032 Buffer contents SHALL NOT be cleared by reset; every interior entry is rewritten before the next DRAIN.
REQ-033 Reset asserted mid-COLLECT or mid-DRAIN SHALL discard the partial frame.
REQ-034 After release, the next accepted pixel SHALL land at interior position (0,0).

Configuration
REQ-035 Macro SOBEL_BIN_EN defined: interior outputs SHALL be 8'd255 if the stored pixel is >= THRESH, else 8'd0; border pixels SHALL remain 8'd0.
REQ-036 Macro SOBEL_BIN_EN undefined: interior outputs SHALL be the stored pixel unmodified, and THRESH SHALL be unused.

Verification
REQ-037 res_x=res_y=5; feed 9 pixels 1..9 with out_ready=1 -> 25 outputs: row0 all 0; row1 = 0,1,2,3,0; row2 = 0,4,5,6,0; row3 = 0,7,8,9,0; row4 all 0; one frame_done pulse.
REQ-038 Same stimulus with out_ready toggling 1/0 each cycle -> identical 25-value sequence, and out_pix stable on every stall cycle.
REQ-039 in_valid held high through DRAIN with in_pix=8'hFF -> no extra writes, and the next frame starts at interior position (0,0).
REQ-040 reset pulsed low after 4 of 9 inputs, then 9 new pixels 10..18 fed -> interior output = 10..18.
REQ-041 SOBEL_BIN_EN defined, THRESH=128; interior inputs 127,128,255,0,... -> outputs 0,255,255,0,...; border = 0.
REQ-042 Default 30x30; two back-to-back 784-pixel frames -> 900 outputs per frame and 2 frame_done pulses; in_ready returns to 1 one cycle after each frame_done.

Source files
------------

// File: rtl/sobel_frame_collector.sv
// sobel_frame_collector
// Collects the (res_x-2)x(res_y-2) interior gradient pixels of a Sobel pass.
// It then streams the full res_x x res_y frame in raster order, with a zero
// border around the collected interior.
//
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_pix    : interior pixel input (ready only in COLLECT)
//   out_valid/out_ready/out_pix : full-frame pixel output (valid only in DRAIN)
//   frame_done      : one-cycle pulse after the last output transfer
//   busy            : high while draining or signalling done
//
// Build option: define SOBEL_BIN_EN to binarize interior outputs against
// THRESH (>= THRESH -> 8'd255, else 8'd0). Without it THRESH has no effect.
module sobel_frame_collector #(
  parameter int          res_x  = 30,
  parameter int          res_y  = 30,
  parameter logic [7:0]  THRESH = 8'd128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_pix,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       busy
);
  localparam int IW    = res_x - 2;
  localparam int IH    = res_y - 2;
  localparam int DEPTH = IW * IH;
  localparam int MAXD  = (res_x > res_y) ? res_x : res_y;
  localparam int CW    = $clog2(MAXD + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Elaboration guard on the frame geometry.
  if (res_x < 3 || res_y < 3 || $bits(THRESH) != 8) begin : g_bad_cfg
    $error("sobel_frame_collector: res_x and res_y must be at least 3");
  end

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   w_row_q, w_row_d, w_col_q, w_col_d;
  logic [CW-1:0]   r_row_q, r_row_d, r_col_q, r_col_d;
  logic            in_ready_q, out_valid_q, frame_done_q, busy_q;

  logic [7:0]      mem [0:DEPTH-1];
  logic [AW-1:0]   waddr, raddr;
  logic [7:0]      rd_pix, int_pix;
  logic            in_xfer, out_xfer, interior;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next-state / counter logic
  always_comb begin
    state_d = state_q;
    w_row_d = w_row_q;
    w_col_d = w_col_q;
    r_row_d = r_row_q;
    r_col_d = r_col_q;
    case (state_q)
      COLLECT: if (in_xfer) begin
        if (w_col_q == CW'(IW - 1)) begin
          w_col_d = '0;
          if (w_row_q == CW'(IH - 1)) begin
            w_row_d = '0;
            state_d = DRAIN;
          end else begin
            w_row_d = w_row_q + CW'(1);
          end
        end else begin
          w_col_d = w_col_q + CW'(1);
        end
      end
      DRAIN: if (out_xfer) begin
        if (r_col_q == CW'(res_x - 1)) begin
          r_col_d = '0;
          if (r_row_q == CW'(res_y - 1)) begin
            r_row_d = '0;
            state_d = DONE;
          end else begin
            r_row_d = r_row_q + CW'(1);
          end
        end else begin
          r_col_d = r_col_q + CW'(1);
        end
      end
      DONE:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // State, counters and registered status outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= COLLECT;
      w_row_q      <= '0;
      w_col_q      <= '0;
      r_row_q      <= '0;
      r_col_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_row_q      <= w_row_d;
      w_col_q      <= w_col_d;
      r_row_q      <= r_row_d;
      r_col_q      <= r_col_d;
      in_ready_q   <= (state_d == COLLECT);
      out_valid_q  <= (state_d == DRAIN);
      frame_done_q <= (state_d == DONE);
      busy_q       <= (state_d != COLLECT);
    end
  end

  // Interior buffer: not reset, every entry is rewritten each frame
  assign waddr = AW'(w_row_q) * AW'(IW) + AW'(w_col_q);
  always_ff @(posedge clk) begin
    if (in_xfer) mem[waddr] <= in_pix;
  end

  // Read path is combinational off the read counters; the buffer is never
  // written during DRAIN, so out_pix is stable across stalls.
  assign interior = (r_row_q != '0) && (r_row_q != CW'(res_y - 1)) &&
                    (r_col_q != '0) && (r_col_q != CW'(res_x - 1));
  assign raddr    = AW'(r_row_q - CW'(1)) * AW'(IW) + AW'(r_col_q - CW'(1));
  assign rd_pix   = mem[raddr];

`ifdef SOBEL_BIN_EN
  assign int_pix = (rd_pix >= THRESH) ? 8'd255 : 8'd0;
`else
  assign int_pix = rd_pix;
`endif

  assign out_pix    = (out_valid_q && interior) ? int_pix : 8'd0;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_sobel_frame_collector.sv
module tb_sobel_frame_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 5x5 instance
  logic       iv5 = 1'b0, ordy5 = 1'b0;
  logic [7:0] ip5 = '0;
  logic       ir5, ov5, fd5, busy5;
  logic [7:0] op5;
  // 30x30 instance
  logic       iv30 = 1'b0, ordy30 = 1'b0;
  logic [7:0] ip30 = '0;
  logic       ir30, ov30, fd30, busy30;
  logic [7:0] op30;

  sobel_frame_collector #(.res_x(5), .res_y(5)) dut5 (
    .clk(clk), .reset(rst_n), .in_valid(iv5), .in_pix(ip5), .in_ready(ir5),
    .out_valid(ov5), .out_pix(op5), .out_ready(ordy5), .frame_done(fd5), .busy(busy5));

  sobel_frame_collector dut30 (
    .clk(clk), .reset(rst_n), .in_valid(iv30), .in_pix(ip30), .in_ready(ir30),
    .out_valid(ov30), .out_pix(op30), .out_ready(ordy30), .frame_done(fd30), .busy(busy30));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: value of one interior pixel as it should appear on the output.
  function automatic logic [7:0] model_px(input logic [7:0] v);
`ifdef SOBEL_BIN_EN
    return (v >= 8'd128) ? 8'd255 : 8'd0;
`else
    return v;
`endif
  endfunction

  // Reference frame: zero border around the raster-ordered interior list.
  function automatic logic [7:0] model_frame(input logic [7:0] pix[9], input int k);
    int r, c;
    r = k / 5;
    c = k % 5;
    if (r == 0 || r == 4 || c == 0 || c == 4) return 8'd0;
    return model_px(pix[(r - 1) * 3 + (c - 1)]);
  endfunction

  typedef struct {
    logic [7:0] pix[9];
    int         mode;   // 0: out_ready=1, 1: toggling, 2: random both sides
    bit         hold;   // keep in_valid=1, in_pix=FF while in_ready=0
    logic [7:0] exp[25];
  } vec_t;

  // One 5x5 frame; returns the transferred output pixels.
  task automatic run5(input logic [7:0] pix[9], input int mode, input bit hold,
                      output logic [7:0] got[25], output int ngot);
    int pi = 0, cyc = 0, last_in = -1, first_ov = -1;
    bit done = 0, prev_stall = 0;
    logic [7:0] prev_pix = '0;
    ngot = 0;
    for (int i = 0; i < 25; i++) got[i] = '0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", ov5, 1);
        chk("stall_pix", op5, prev_pix);
      end
      if (ov5 && first_ov < 0) begin
        first_ov = cyc;
        chk("drain_busy", busy5, 1);
        chk("drain_in_ready", ir5, 0);
      end
      if (fd5) begin
        done = 1;
        chk("done_out_valid", ov5, 0);
        chk("done_busy", busy5, 1);
      end
      if (ir5 && pi < 9) begin
        iv5 = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        ip5 = pix[pi];
      end else if (!ir5 && hold) begin
        iv5 = 1'b1;
        ip5 = 8'hFF;
      end else begin
        iv5 = 1'b0;
      end
      case (mode)
        0:       ordy5 = 1'b1;
        1:       ordy5 = cyc[0];
        default: ordy5 = 1'($urandom_range(0, 1));
      endcase
      if (iv5 && ir5) begin
        pi++;
        last_in = cyc;
      end
      if (ov5 && ordy5) begin
        if (ngot < 25) got[ngot] = op5;
        ngot++;
      end
      prev_stall = ov5 && !ordy5;
      prev_pix   = op5;
      cyc++;
    end
    chk("frame_done_seen", done, 1);
    chk("out_latency", first_ov, last_in + 1);
    @(negedge clk);
    chk("post_in_ready", ir5, 1);
    chk("post_frame_done", fd5, 0);
    chk("post_busy", busy5, 0);
    iv5 = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] got[25], input int ngot,
                             input logic [7:0] exp[25]);
    chk({name, "_count"}, ngot, 25);
    for (int i = 0; i < 25; i++) chk($sformatf("%s_px%0d", name, i), got[i], exp[i]);
  endtask

  // One 30x30 frame of random pixels with random out_ready.
  int fd30_cnt = 0;
  task automatic run30(input string name);
    logic [7:0] p[784];
    int pi = 0, nout = 0, mism = 0, cyc = 0, r, c;
    bit done = 0;
    logic [7:0] e;
    for (int i = 0; i < 784; i++) p[i] = 8'($urandom);
    while (!done && cyc < 10000) begin
      @(negedge clk);
      if (cyc == 0) chk({name, "_ready_at_start"}, ir30, 1);
      if (fd30) begin
        done = 1;
        fd30_cnt++;
      end
      iv30   = ir30 && pi < 784;
      ip30   = (pi < 784) ? p[pi] : 8'd0;
      ordy30 = 1'($urandom_range(0, 1));
      if (iv30 && ir30) pi++;
      if (ov30 && ordy30) begin
        r = nout / 30;
        c = nout % 30;
        e = (r == 0 || r == 29 || c == 0 || c == 29) ? 8'd0 : model_px(p[(r - 1) * 28 + c - 1]);
        if (op30 !== e) begin
          if (mism == 0) $display("FAIL %s_pix%0d: got %0d expected %0d", name, nout, op30, e);
          mism++;
        end
        nout++;
      end
      cyc++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_outputs"}, nout, 900);
    chk({name, "_mismatches"}, mism, 0);
  endtask

  vec_t tbl[4];
  logic [7:0] got[25];
  logic [7:0] rp[9];
  logic [7:0] ex[25];
  int ngot;

  initial begin
`ifdef SOBEL_BIN_EN
    tbl[0].pix = '{127, 128, 255, 0, 200, 50, 128, 127, 129};
    tbl[0].exp = '{0,0,0,0,0, 0,0,255,255,0, 0,0,255,0,0, 0,255,0,255,0, 0,0,0,0,0};
    tbl[2].pix = '{255, 0, 255, 0, 255, 0, 255, 0, 255};
    tbl[2].exp = '{0,0,0,0,0, 0,255,0,255,0, 0,0,255,0,0, 0,255,0,255,0, 0,0,0,0,0};
`else
    tbl[0].pix = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[0].exp = '{0,0,0,0,0, 0,1,2,3,0, 0,4,5,6,0, 0,7,8,9,0, 0,0,0,0,0};
    tbl[2].pix = '{20, 21, 22, 23, 24, 25, 26, 27, 28};
    tbl[2].exp = '{0,0,0,0,0, 0,20,21,22,0, 0,23,24,25,0, 0,26,27,28,0, 0,0,0,0,0};
`endif
    tbl[0].mode = 0; tbl[0].hold = 0;
    tbl[1] = tbl[0]; tbl[1].mode = 1;
    tbl[2].mode = 0; tbl[2].hold = 1;
    tbl[3] = tbl[0]; tbl[3].mode = 2;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir5, 1);
    chk("rst_out_valid", ov5, 0);
    chk("rst_out_pix", op5, 0);
    chk("rst_frame_done", fd5, 0);
    chk("rst_busy", busy5, 0);
    chk("rst30_in_ready", ir30, 1);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      run5(tbl[t].pix, tbl[t].mode, tbl[t].hold, got, ngot);
      check_frame($sformatf("tbl%0d", t), got, ngot, tbl[t].exp);
    end

    // Reset in the middle of collection discards the partial frame
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv5 = 1'b1;
      ip5 = 8'(50 + i);
    end
    @(negedge clk);
    iv5 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir5, 1);
    chk("midrst_out_valid", ov5, 0);
    chk("midrst_busy", busy5, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) rp[i] = 8'(10 + i);
    for (int k = 0; k < 25; k++) ex[k] = model_frame(rp, k);
    run5(rp, 0, 0, got, ngot);
    check_frame("after_rst", got, ngot, ex);

    // Reset in the middle of draining
    run5(rp, 0, 0, got, ngot);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      iv5 = 1'b1;
      ip5 = 8'(100 + i);
    end
    @(negedge clk);
    iv5 = 1'b0;
    @(negedge clk);
    chk("drain_before_rst", ov5, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("drainrst_out_valid", ov5, 0);
    chk("drainrst_out_pix", op5, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random frames against the reference model
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++) rp[i] = 8'($urandom);
      for (int k = 0; k < 25; k++) ex[k] = model_frame(rp, k);
      run5(rp, 2, f[0], got, ngot);
      check_frame($sformatf("rand%0d", f), got, ngot, ex);
    end

    // Default 30x30: two back-to-back frames
    run30("f30a");
    run30("f30b");
    @(negedge clk);
    chk("f30_ready_after", ir30, 1);
    chk("f30_no_extra_done", fd30, 0);
    chk("f30_done_pulses", fd30_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
